sar_search4: RTL and testbench

//  - Successive-approximation search controller; sits directly upstream of the 4-bit magnitude comparator.
//  - Drives the comparator's in2 with a trial value (guess); comparator in1 carries an unknown target.
//  - Consumes the comparator's low/equal/great flags and resolves the target MSB-first in <= WIDTH trials.
//  - Reports the resolved value and trial count.

---
 rtl/sar_search_pkg.sv | 19 +
 rtl/sar_search4_if.sv | 29 ++
 rtl/sar_search4.sv | 138 +++++++++++++
 tb/tb_sar_search4.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_search_pkg.sv
// Shared types and widths for the successive-approximation search controller.
// The state encoding and counter widths are common to the RTL and its bench.
package sar_search_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRY  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SETTLE_W = 3;
    localparam int STEPS_W  = 3;

    // True when exactly one of the three comparator flags is asserted.
    function automatic logic onehot3(input logic a, input logic b, input logic c);
        return (a & ~b & ~c) | (~a & b & ~c) | (~a & ~b & c);
    endfunction

endpackage

// File: rtl/sar_search4_if.sv
// Bundle between the search controller and its comparator/host side.
// Comparator flags flow in, the trial value and search status flow out.
interface sar_search4_if #(
    parameter int WIDTH = 4
);
    import sar_search_pkg::*;

    logic               start;
    logic               low;
    logic               equal;
    logic               great;
    logic [WIDTH-1:0]   guess;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;
    logic [STEPS_W-1:0] steps;
    logic               err;

    modport master (
        output start, low, equal, great,
        input  guess, busy, done, result, steps, err
    );

    modport slave (
        input  start, low, equal, great,
        output guess, busy, done, result, steps, err
    );

endinterface

// File: rtl/sar_search4.sv
// Successive-approximation search controller: resolves a comparator target MSB-first.
// Define SAR_SEARCH_FLAGCHK_EN to flag non-one-hot comparator flags through err.
module sar_search4
    import sar_search_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 0
) (
    input  logic          clk,
    input  logic          rst,
    sar_search4_if.slave  bus
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0]    TOP_BIT     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0]    TOP_IDX     = IDX_W'(WIDTH - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE);

    state_t               state_reg,  state_next;
    logic [IDX_W-1:0]     idx_reg,    idx_next;
    logic [WIDTH-1:0]     trial_reg,  trial_next;
    logic [WIDTH-1:0]     acc_reg,    acc_next;
    logic [WIDTH-1:0]     result_reg, result_next;
    logic [STEPS_W-1:0]   steps_reg,  steps_next;
    logic                 err_reg,    err_next;
    logic [SETTLE_W-1:0]  settle_reg, settle_next;

    logic [WIDTH-1:0]     acc_upd;
    logic [WIDTH-1:0]     next_mask;
    logic                 flag_bad;
    logic                 unused_low;

    // acc_upd: accumulator with the bit under test set from the great flag
    // (equal is handled before this is used, so low and all-zero both clear it).
    // next_mask: the bit one position below the current index.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign acc_upd[gi]   = (int'(idx_reg) == gi)     ? bus.great : acc_reg[gi];
        assign next_mask[gi] = (int'(idx_reg) == gi + 1);
    end

`ifdef SAR_SEARCH_FLAGCHK_EN
    assign flag_bad = ~onehot3(bus.low, bus.equal, bus.great);
`else
    assign flag_bad = 1'b0;
`endif

    // low only matters for the one-hot check; otherwise it is the implied default.
    assign unused_low = bus.low;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            trial_reg  <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
            steps_reg  <= '0;
            err_reg    <= 1'b0;
            settle_reg <= '0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            trial_reg  <= trial_next;
            acc_reg    <= acc_next;
            result_reg <= result_next;
            steps_reg  <= steps_next;
            err_reg    <= err_next;
            settle_reg <= settle_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        trial_next  = trial_reg;
        acc_next    = acc_reg;
        result_next = result_reg;
        steps_next  = steps_reg;
        err_next    = err_reg;
        settle_next = settle_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next  = TRY;
                    idx_next    = TOP_IDX;
                    trial_next  = TOP_BIT;
                    acc_next    = '0;
                    steps_next  = '0;
                    err_next    = 1'b0;
                    settle_next = SETTLE_INIT;
                end
            end

            TRY: begin
                if (settle_reg != '0) begin
                    settle_next = settle_reg - SETTLE_W'(1);
                end else begin
                    steps_next = steps_reg + STEPS_W'(1);
                    if (flag_bad) begin
                        err_next    = 1'b1;
                        result_next = trial_reg;
                        state_next  = DONE;
                    end else if (bus.equal) begin
                        result_next = trial_reg;
                        state_next  = DONE;
                    end else if (idx_reg == '0) begin
                        acc_next    = acc_upd;
                        result_next = acc_upd;
                        state_next  = DONE;
                    end else begin
                        acc_next    = acc_upd;
                        idx_next    = idx_reg - IDX_W'(1);
                        trial_next  = acc_upd | next_mask;
                        settle_next = SETTLE_INIT;
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outside a search the comparator sees the last resolved value.
    assign bus.busy   = (state_reg == TRY);
    assign bus.done   = (state_reg == DONE);
    assign bus.guess  = (state_reg == TRY) ? trial_reg : result_reg;
    assign bus.result = result_reg;
    assign bus.steps  = steps_reg;
    assign bus.err    = err_reg;

endmodule

// File: tb/tb_sar_search4.sv
// Bench for sar_search4: two instances (SETTLE=0 and SETTLE=2) each paired with a
// behavioural 4-bit comparator; table vectors, hand sequences and random searches.
module tb_sar_search4;
    import sar_search_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a    [2];
    logic       start_a  [2];
    logic [3:0] target_a [2];
    logic       inj_a    [2];
    logic [3:0] guess_a  [2];
    logic [3:0] result_a [2];
    logic       busy_a   [2];
    logic       done_a   [2];
    logic       err_a    [2];
    logic [2:0] steps_a  [2];

    int checks = 0;
    int errors = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int ST = (gi == 0) ? 0 : 2;
        sar_search4_if #(.WIDTH(4)) bus ();
        logic inj_hit;

        // Fault injection: on the first trial (guess 1000) drive low=great=1.
        assign inj_hit   = inj_a[gi] && bus.busy && (bus.guess == 4'b1000);
        assign bus.start = start_a[gi];
        assign bus.low   = inj_hit | (target_a[gi] <  bus.guess);
        assign bus.great = inj_hit | (target_a[gi] >  bus.guess);
        assign bus.equal = ~inj_hit & (target_a[gi] == bus.guess);

        assign guess_a[gi]  = bus.guess;
        assign result_a[gi] = bus.result;
        assign busy_a[gi]   = bus.busy;
        assign done_a[gi]   = bus.done;
        assign err_a[gi]    = bus.err;
        assign steps_a[gi]  = bus.steps;

        sar_search4 #(.WIDTH(4), .SETTLE(ST)) dut (
            .clk (clk),
            .rst (rst_a[gi]),
            .bus (bus)
        );
    end

    typedef struct {
        int         d;
        logic [3:0] t;
        bit         inj;
        bit         pulse;
        logic [3:0] res;
        int         st;
        bit         e;
        int         lat;
        logic [15:0] gl;
        int         gn;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: binary search from the rules, guesses packed 4 bits each, oldest first.
    function automatic void model(input logic [3:0] t, input bit inj,
                                  output logic [3:0] res, output int st, output bit e,
                                  output logic [15:0] gl, output int gn);
        logic [3:0] acc;
        logic [3:0] g;
        bit eq, gr;
        acc = 4'd0; res = 4'd0; st = 0; e = 1'b0; gl = 16'd0; gn = 0;
        for (int i = 3; i >= 0; i--) begin
            g  = acc | (4'd1 << i);
            gl = {gl[11:0], g};
            gn++;
            st++;
            eq = (t == g);
            gr = (t > g);
`ifdef SAR_SEARCH_FLAGCHK_EN
            if (inj && i == 3) begin
                e   = 1'b1;
                res = g;
                return;
            end
`else
            if (inj && i == 3) begin
                eq = 1'b0;
                gr = 1'b1;
            end
`endif
            if (eq) begin
                res = g;
                return;
            end
            if (gr) acc = acc | (4'd1 << i);
            if (i == 0) res = acc;
        end
    endfunction

    task automatic run_search(input int d, input logic [3:0] t, input bit inj, input bit pulse,
                              output logic [3:0] res, output int st, output bit e, output int lat,
                              output logic [15:0] gl, output int gn, output logic [3:0] gd,
                              output bit timeout);
        int n;
        res = 4'd0; st = 0; e = 1'b0; lat = 0; gl = 16'd0; gn = 0; gd = 4'd0; timeout = 1'b1;
        @(negedge clk);
        target_a[d] = t;
        inj_a[d]    = inj;
        start_a[d]  = 1'b1;
        @(negedge clk);
        n = 0;
        while (n < 200) begin
            if (busy_a[d] && (gn == 0 || guess_a[d] != gl[3:0])) begin
                gl = {gl[11:0], guess_a[d]};
                gn++;
            end
            if (done_a[d]) begin
                timeout = 1'b0;
                lat = n + 1;
                res = result_a[d];
                st  = int'(steps_a[d]);
                e   = err_a[d];
                gd  = guess_a[d];
                break;
            end
            start_a[d] = pulse && (n == 2) && busy_a[d];
            @(negedge clk);
            n++;
        end
        start_a[d] = 1'b0;
        inj_a[d]   = 1'b0;
    endtask

    task automatic check_run(input string tag, input int d, input logic [3:0] t,
                             input bit inj, input bit pulse,
                             input logic [3:0] xres, input int xst, input bit xe,
                             input int xlat, input logic [15:0] xgl, input int xgn);
        logic [3:0] res, gd;
        int st, lat, gn;
        bit e, timeout;
        logic [15:0] gl;
        run_search(d, t, inj, pulse, res, st, e, lat, gl, gn, gd, timeout);
        chk({tag, "_timeout"}, int'(timeout), 0);
        chk({tag, "_result"},  int'(res), int'(xres));
        chk({tag, "_steps"},   st, xst);
        chk({tag, "_err"},     int'(e), int'(xe));
        chk({tag, "_latency"}, lat, xlat);
        chk({tag, "_guesses"}, int'(gl), int'(xgl));
        chk({tag, "_ntrials"}, gn, xgn);
        chk({tag, "_guess_eq_result"}, int'(gd), int'(xres));
        @(negedge clk);
        chk({tag, "_done_1cyc"}, int'(done_a[d]), 0);
        $display("txn %s dut%0d target=%0d result=%0d steps=%0d err=%0d latency=%0d",
                 tag, d, t, res, st, e, lat);
    endtask

    initial begin
        logic [3:0] mres;
        int mst, n, sett;
        bit me;
        logic [15:0] mgl;
        int mgn;

        tbl[0] = '{0, 4'd8,  1'b0, 1'b0, 4'd8,  1, 1'b0, 2,  16'h0008, 1};
        tbl[1] = '{0, 4'd0,  1'b0, 1'b0, 4'd0,  4, 1'b0, 5,  16'h8421, 4};
        tbl[2] = '{0, 4'd15, 1'b0, 1'b0, 4'd15, 4, 1'b0, 5,  16'h8CEF, 4};
        tbl[3] = '{1, 4'd5,  1'b0, 1'b1, 4'd5,  4, 1'b0, 13, 16'h8465, 4};
`ifdef SAR_SEARCH_FLAGCHK_EN
        tbl[4] = '{0, 4'd3,  1'b1, 1'b0, 4'd8,  1, 1'b1, 2,  16'h0008, 1};
`else
        tbl[4] = '{0, 4'd3,  1'b1, 1'b0, 4'd8,  4, 1'b0, 5,  16'h8CA9, 4};
`endif

        for (int d = 0; d < 2; d++) begin
            rst_a[d] = 1'b1; start_a[d] = 1'b0; target_a[d] = 4'd0; inj_a[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d_guess", d),  int'(guess_a[d]), 0);
            chk($sformatf("rst%0d_result", d), int'(result_a[d]), 0);
            chk($sformatf("rst%0d_steps", d),  int'(steps_a[d]), 0);
            chk($sformatf("rst%0d_busy", d),   int'(busy_a[d]), 0);
            chk($sformatf("rst%0d_done", d),   int'(done_a[d]), 0);
            chk($sformatf("rst%0d_err", d),    int'(err_a[d]), 0);
        end
        rst_a[0] = 1'b0;
        rst_a[1] = 1'b0;

        for (int i = 0; i < 5; i++) begin
            check_run($sformatf("tbl%0d", i), tbl[i].d, tbl[i].t, tbl[i].inj, tbl[i].pulse,
                      tbl[i].res, tbl[i].st, tbl[i].e, tbl[i].lat, tbl[i].gl, tbl[i].gn);
        end

        // Reset during the second trial aborts the search and clears every output.
        @(negedge clk);
        target_a[0] = 4'd11;
        start_a[0]  = 1'b1;
        @(negedge clk);
        start_a[0]  = 1'b0;
        chk("t5_busy_trial1", int'(busy_a[0]), 1);
        chk("t5_guess_trial1", int'(guess_a[0]), 8);
        @(negedge clk);
        chk("t5_guess_trial2", int'(guess_a[0]), 12);
        rst_a[0] = 1'b1;
        @(negedge clk);
        chk("t5_rst_busy",   int'(busy_a[0]), 0);
        chk("t5_rst_done",   int'(done_a[0]), 0);
        chk("t5_rst_guess",  int'(guess_a[0]), 0);
        chk("t5_rst_result", int'(result_a[0]), 0);
        chk("t5_rst_steps",  int'(steps_a[0]), 0);
        chk("t5_rst_err",    int'(err_a[0]), 0);
        $display("txn t5_reset dut0 busy=%0d result=%0d", busy_a[0], result_a[0]);
        rst_a[0] = 1'b0;
        check_run("t5_fresh", 0, 4'd11, 1'b0, 1'b0, 4'd11, 4, 1'b0, 5, 16'h8CAB, 4);

        // start held high through DONE: IDLE for one cycle, then a new search.
        @(negedge clk);
        target_a[1] = 4'd6;
        start_a[1]  = 1'b1;
        n = 0;
        while (!done_a[1] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("held_timeout", int'(n < 100), 1);
        chk("held_result", int'(result_a[1]), 6);
        chk("held_steps",  int'(steps_a[1]), 3);
        @(negedge clk);
        chk("held_idle_busy", int'(busy_a[1]), 0);
        chk("held_idle_done", int'(done_a[1]), 0);
        @(negedge clk);
        chk("held_restart_busy",  int'(busy_a[1]), 1);
        chk("held_restart_guess", int'(guess_a[1]), 8);
        start_a[1] = 1'b0;
        n = 0;
        while (!done_a[1] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("held2_timeout", int'(n < 100), 1);
        chk("held2_result", int'(result_a[1]), 6);
        $display("txn held_start dut1 target=6 result=%0d steps=%0d", result_a[1], steps_a[1]);

        for (int r = 0; r < 40; r++) begin
            int  d;
            logic [3:0] t;
            bit  inj, pulse;
            d     = int'($urandom_range(0, 1));
            t     = 4'($urandom_range(0, 15));
            inj   = ($urandom_range(0, 7) == 0);
            pulse = ($urandom_range(0, 1) == 1);
            sett  = (d == 0) ? 0 : 2;
            model(t, inj, mres, mst, me, mgl, mgn);
            check_run($sformatf("rnd%0d", r), d, t, inj, pulse,
                      mres, mst, me, mst * (sett + 1) + 1, mgl, mgn);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
